laplace_exacto_core: RTL and testbench
======================================

Name: laplace_exacto_core

Overview:
Exact (non-approximate) 4-neighbour Laplacian kernel for 8-bit greyscale images. Per pixel it takes the centre pixel and its four orthogonal neighbours and computes 4·e − b − d − f − h at full precision. The magnitude is saturated to 8 bits and the sign is reported separately. The block sits after the line-buffer/window generator in the image-filter pipeline. Downstream logic writes s[7:0] as the filtered pixel.

Parameters:
PIX_W, 8, pixel width in bits; s is PIX_W+1 bits.
(Internal result width is PIX_W+3, signed; derived, not a parameter.)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  b/d/e/f/h are valid this cycle
b  input  PIX_W  upper neighbour (row−1, col)
d  input  PIX_W  left neighbour (row, col−1)
e  input  PIX_W  centre pixel (row, col)
f  input  PIX_W  right neighbour (row, col+1)
h  input  PIX_W  lower neighbour (row+1, col)
out_valid  output  1  s holds a new result
s  output  PIX_W+1  s[PIX_W] = sign (1 = negative Laplacian); s[PIX_W-1:0] = saturated magnitude

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset: when rst=1 at a rising edge, all pipeline registers, out_valid and s clear to 0. rst has priority over in_valid.
- Arithmetic: all operands are unsigned. r = 4·e − (b + d + f + h) is computed exactly in PIX_W+3 signed bits. Range is −1020..+1020 for PIX_W=8. No intermediate truncation is allowed.
  - Neighbour sum: the 4-input sum uses PIX_W+2 bits.
  - Centre term: 4·e is e shifted left by 2.
- Output mapping:
  - Sign: s[PIX_W] = 1 iff r < 0.
  - Magnitude: s[PIX_W-1:0] = min(|r|, 2^PIX_W − 1).
  - r = 0 gives s = 0 with the sign bit cleared. There is never a negative zero.
- Pipeline: 2 register stages, so latency is exactly 2 cycles.
  - Stage 1 registers two terms: (b+d)+(f+h) and 4·e. It also registers a copy of in_valid.
  - Stage 2 registers the subtraction, abs, saturation and sign into s and out_valid.
- Throughput: one pixel per cycle. There is no backpressure; the block is always ready.
- Idle: when in_valid=0, out_valid follows 2 cycles later as 0, and s holds its last value. s is not cleared.
- Back-to-back: consecutive valid inputs produce consecutive valid outputs in the same order, with no bubbles.
- Reset mid-stream: both stages flush. Results for inputs accepted in the 2 cycles before rst are discarded. Normal operation resumes on the first cycle after rst deasserts.
- X on data inputs while in_valid=0 must not propagate to out_valid.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 and random data -> out_valid=0 and s=9'h000 throughout.
2. Flat field b=d=e=f=h=100, in_valid for 1 cycle -> 2 cycles later out_valid=1 and s=9'h000.
3. Positive result: e=10, b=d=f=h=0 -> s=9'h028 (sign 0, magnitude 40). Then e=255, neighbours 0 (r=1020) -> s=9'h0FF (saturated).
4. Negative result: e=0, neighbours 10 -> s=9'h128 (sign 1, magnitude 40). Then e=0, neighbours 255 (r=−1020) -> s=9'h1FF. Then e=50, b=d=f=h=51 (r=−4) -> s=9'h104.
5. Streaming: 510 consecutive random 5-tuples with in_valid held high. Every output must match the software model, in order, at 2-cycle latency, with no gaps. Then drop in_valid for 3 cycles -> out_valid falls 2 cycles later and s holds its last value.
6. Mid-stream reset: stream valid data, pulse rst for 1 cycle -> out_valid is 0 for the next 2 cycles. The first input after rst is released produces a correct result 2 cycles later.

Source files
------------

// File: rtl/laplace_exacto_core.sv
// laplace_exacto_core: exact 4-neighbour Laplacian (4e - b - d - f - h) for
// greyscale pixels. Two register stages. The output is a sign bit plus an
// 8-bit magnitude that saturates at full scale.
module laplace_exacto_core #(
  parameter int unsigned PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   b,
  input  logic [PIX_W-1:0]   d,
  input  logic [PIX_W-1:0]   e,
  input  logic [PIX_W-1:0]   f,
  input  logic [PIX_W-1:0]   h,
  output logic               out_valid,
  output logic [PIX_W:0]     s
);

  // Neighbour sum and centre term both fit in PIX_W+2 bits without loss.
  localparam int unsigned SUM_W = PIX_W + 2;

  logic [SUM_W-1:0] sum_d, sum_q;
  logic [SUM_W-1:0] cen_d, cen_q;
  logic             vld_q;

  logic [SUM_W-1:0] mag_c;
  logic             neg_c;
  logic             sat_c;
  logic [PIX_W:0]   s_d, s_q;
  logic             out_valid_q;

  // Stage 1 operands: pairwise neighbour sum and the centre pixel scaled by 4.
  always_comb begin
    sum_d = (SUM_W'(b) + SUM_W'(d)) + (SUM_W'(f) + SUM_W'(h));
    cen_d = {e, 2'b00};
  end

  // Stage 1 registers. Data loads only on valid so idle X never enters the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cen_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_d;
        cen_q <= cen_d;
      end
    end
  end

  // Stage 2 math: the sign comes from a compare, and |r| is the exact difference in the right order.
  always_comb begin
    neg_c = (sum_q > cen_q);
    mag_c = neg_c ? SUM_W'(sum_q - cen_q) : SUM_W'(cen_q - sum_q);
    sat_c = |mag_c[SUM_W-1:PIX_W];
    s_d   = {neg_c, (sat_c ? {PIX_W{1'b1}} : mag_c[PIX_W-1:0])};
  end

  // Stage 2 registers. s holds its last result while the pipe is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_q;
      if (vld_q) begin
        s_q <= s_d;
      end
    end
  end

  assign s         = s_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_laplace_exacto_core.sv
// Directed bench for laplace_exacto_core. It checks against hand-computed
// constants and an integer reference model.
module tb_laplace_exacto_core;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned NSTREAM = 510;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [PIX_W-1:0] b, d, e, f, h;
  logic             out_valid;
  logic [PIX_W:0]   s;

  int checks;
  int failures;

  logic [PIX_W:0] exp_s [NSTREAM];
  logic [PIX_W:0] last_s;
  logic [PIX_W:0] rst_exp;

  laplace_exacto_core #(.PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .b         (b),
    .d         (d),
    .e         (e),
    .f         (f),
    .h         (h),
    .out_valid (out_valid),
    .s         (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer reference model: full-precision r, then sign and saturated magnitude.
  function automatic logic [8:0] model(input int vb, input int vd, input int ve,
                                       input int vf, input int vh);
    int r;
    int m;
    r = 4 * ve - vb - vd - vf - vh;
    m = (r < 0) ? -r : r;
    if (m > 255) m = 255;
    return {((r < 0) ? 1'b1 : 1'b0), 8'(m)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [7:0] vb, input logic [7:0] vd, input logic [7:0] ve,
                       input logic [7:0] vf, input logic [7:0] vh);
    b = vb; d = vd; e = ve; f = vf; h = vh;
  endtask

  task automatic drive_rand();
    b = 8'($urandom); d = 8'($urandom); e = 8'($urandom);
    f = 8'($urandom); h = 8'($urandom);
  endtask

  // Present one vector for a single cycle, put X on the data afterwards, then check the result and the hold.
  task automatic one_shot(input string tag, input logic [7:0] vb, input logic [7:0] vd,
                          input logic [7:0] ve, input logic [7:0] vf, input logic [7:0] vh,
                          input logic [8:0] expv);
    drive(vb, vd, ve, vf, vh);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    b = 'x; d = 'x; e = 'x; f = 'x; h = 'x;
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_s"}, 32'(s), 32'(expv));
    tick();
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_hold_s"}, 32'(s), 32'(expv));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b1;
    drive_rand();

    // Reset held for two cycles with valid random data on the inputs
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_s", 32'(s), 32'h000);
      drive_rand();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_s", 32'(s), 32'h000);

    // Directed vectors
    one_shot("flat",     8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 9'h000);
    one_shot("pos40",    8'd0,   8'd0,   8'd10,  8'd0,   8'd0,   9'h028);
    one_shot("pos_sat",  8'd0,   8'd0,   8'd255, 8'd0,   8'd0,   9'h0FF);
    one_shot("neg40",    8'd10,  8'd10,  8'd0,   8'd10,  8'd10,  9'h128);
    one_shot("neg_sat",  8'd255, 8'd255, 8'd0,   8'd255, 8'd255, 9'h1FF);
    one_shot("neg4",     8'd51,  8'd51,  8'd50,  8'd51,  8'd51,  9'h104);
    one_shot("pos255",   8'd0,   8'd0,   8'd64,  8'd0,   8'd1,   9'h0FF);
    one_shot("pos256",   8'd0,   8'd0,   8'd64,  8'd0,   8'd0,   9'h0FF);
    one_shot("neg255",   8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   9'h1FF);

    // Continuous stream of random tuples, followed by three idle cycles
    for (int i = 0; i <= int'(NSTREAM); i++) begin
      if (i < int'(NSTREAM)) begin
        drive_rand();
        in_valid = 1'b1;
        exp_s[i] = model(int'(b), int'(d), int'(e), int'(f), int'(h));
      end else begin
        in_valid = 1'b0;
        b = 'x; d = 'x; e = 'x; f = 'x; h = 'x;
      end
      tick();
      if (i >= 1) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_s", 32'(s), 32'(exp_s[i-1]));
      end
    end
    last_s = exp_s[NSTREAM-1];
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_hold_s", 32'(s), 32'(last_s));
    end

    // Mid-stream reset: the stream runs, then rst pulses for one cycle
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      in_valid = 1'b1;
      exp_s[i] = model(int'(b), int'(d), int'(e), int'(f), int'(h));
      tick();
      if (i >= 1) check("pre_rst_s", 32'(s), 32'(exp_s[i-1]));
    end
    drive_rand();
    rst = 1'b1;
    tick();
    check("mid_rst_valid0", 32'(out_valid), 32'd0);
    check("mid_rst_s", 32'(s), 32'h000);
    rst = 1'b0;
    drive(8'd1, 8'd2, 8'd20, 8'd3, 8'd4);
    rst_exp = 9'h046;
    tick();
    check("mid_rst_valid1", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    b = 'x; d = 'x; e = 'x; f = 'x; h = 'x;
    tick();
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_s", 32'(s), 32'(rst_exp));
    tick();
    check("resume_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
